// File: rtl/disp_pkg.sv
// Shared definitions for the multi-channel display register controller:
// register offsets, interrupt status bit positions and parameter defaults.
package disp_pkg;

    typedef logic [11:0] reg_addr_t;
    typedef logic [3:0]  ch_off_t;

    // Parameter defaults
    localparam int NCH_DEF = 2;
    localparam int AW_DEF  = 29;
    localparam int FCW_DEF = 16;

    // Global register offsets
    localparam reg_addr_t REG_DISPCTRL  = 12'h000;
    localparam reg_addr_t REG_DISPIEN   = 12'h004;
    localparam reg_addr_t REG_DISPISTAT = 12'h008;
    localparam reg_addr_t REG_DISPFIFO  = 12'h00C;
    localparam reg_addr_t REG_FRAMECNT  = 12'h010;

    // Per-channel register window
    localparam reg_addr_t CH_BASE   = 12'h100;
    localparam reg_addr_t CH_STRIDE = 12'h010;
    localparam ch_off_t   CH_SHADOW = 4'h0;
    localparam ch_off_t   CH_CTRL   = 4'h4;
    localparam ch_off_t   CH_ACTIVE = 4'h8;

    // Interrupt status / enable bit positions
    localparam int ISTAT_VBLANK = 0;
    localparam int ISTAT_UNDER  = 1;
    localparam int ISTAT_OVER   = 2;

    // Absolute address of a channel register
    function automatic reg_addr_t ch_reg_addr(input int unsigned c, input ch_off_t off);
        return CH_BASE + reg_addr_t'(c) * CH_STRIDE + {8'h00, off};
    endfunction

endpackage

// File: rtl/disp_ch_regs.sv
// One display channel: byte-writable SHADOW address, UPDREQ handshake,
// ACTIVE (scan-out) address and channel enable.
module disp_ch_regs #(
    parameter int AW = disp_pkg::AW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_shadow_we,
    input  logic [3:0]    i_byteen,
    input  logic [31:0]   i_wdata,
    input  logic          i_ctrl_we,
    input  logic          i_dispon,
    input  logic          i_vsync_fall,
    output logic [AW-1:0] o_shadow,
    output logic [AW-1:0] o_active,
    output logic          o_ch_en,
    output logic          o_updreq
);

    logic [AW-1:0] r_shadow;
    logic [AW-1:0] r_active;
    logic          r_ch_en;
    logic          r_updreq;
    logic [AW-1:0] w_shadow_next;
    logic          w_xfer;
    logic          w_upd_set;
    logic          w_unused;

    // Upper write-data bits beyond AW have no storage
    assign w_unused  = ^i_wdata;

    // A pending request is consumed by the frame boundary; the SHADOW sampled
    // is the registered one, so a write landing on the same edge is not seen
    assign w_xfer    = i_vsync_fall && r_updreq;
    assign w_upd_set = i_ctrl_we && i_wdata[1];

    // Byte-lane merge of write data into SHADOW
    always_comb begin
        w_shadow_next = r_shadow;
        for (int i = 0; i < AW; i++) begin
            if (i_shadow_we && i_byteen[i / 8]) begin
                w_shadow_next[i] = i_wdata[i];
            end
        end
    end

    // SHADOW and channel enable registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
            r_ch_en  <= 1'b0;
        end else begin
            r_shadow <= w_shadow_next;
            if (i_ctrl_we) begin
                r_ch_en <= i_wdata[0];
            end
        end
    end

    // ACTIVE follows SHADOW freely while the display is off, else only on a granted update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= '0;
        end else if (!i_dispon || w_xfer) begin
            r_active <= r_shadow;
        end
    end

    // UPDREQ: a new request wins over the clear so it carries into the next frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_updreq <= 1'b0;
        end else if (w_upd_set) begin
            r_updreq <= 1'b1;
        end else if (!i_dispon || w_xfer) begin
            r_updreq <= 1'b0;
        end
    end

    assign o_shadow = r_shadow;
    assign o_active = r_active;
    assign o_ch_en  = r_ch_en;
    assign o_updreq = r_updreq;

endmodule

// File: rtl/disp_regctrl_mc.sv
// Multi-channel display register controller: register decode, VSYNC and
// overflow synchronisers, interrupt status, frame counter and read mux.
module disp_regctrl_mc #(
    parameter int NCH = disp_pkg::NCH_DEF,
    parameter int AW  = disp_pkg::AW_DEF,
    parameter int FCW = disp_pkg::FCW_DEF
) (
    input  logic              ACLK,
    input  logic              ARST_N,
    input  logic              DSP_VSYNC_X,
    input  logic [15:0]       WRADDR,
    input  logic [3:0]        BYTEEN,
    input  logic              WREN,
    input  logic [31:0]       WDATA,
    input  logic [15:0]       RDADDR,
    input  logic              RDEN,
    output logic [31:0]       RDATA,
    output logic              DISPON,
    output logic [NCH-1:0]    CH_EN,
    output logic [NCH*AW-1:0] DISPADDR,
    output logic              DSP_IRQ,
    input  logic [NCH-1:0]    BUF_UNDER,
    input  logic [NCH-1:0]    BUF_OVER
);

    import disp_pkg::*;

    logic            r_dispon;
    logic [2:0]      r_ien;
    logic [2:0]      r_istat;
    logic [NCH-1:0]  r_under;
    logic [NCH-1:0]  r_over;
    logic [FCW-1:0]  r_framecnt;
    logic            r_irq;
    logic [2:0]      r_vs_sync;
    logic [NCH-1:0]  r_over_s1;
    logic [NCH-1:0]  r_over_s2;

    logic            w_wr;
    reg_addr_t       w_wa;
    reg_addr_t       w_ra;
    logic            w_vsync_fall;
    logic [2:0]      w_istat_set;
    logic [2:0]      w_istat_clr;
    logic [NCH-1:0]  w_under_clr;
    logic [NCH-1:0]  w_over_clr;
    logic            w_unused;
    logic [AW-1:0]   w_shadow [NCH];
    logic [AW-1:0]   w_active [NCH];
    logic [NCH-1:0]  w_updreq;

    // Reads are combinational from RDADDR, so the strobe carries no information
    assign w_unused = RDEN;

    assign w_wr = WREN && (WRADDR[15:12] == 4'h0);
    assign w_wa = WRADDR[11:0];
    assign w_ra = RDADDR[11:0];

    // Falling edge seen between the two oldest synchroniser stages
    assign w_vsync_fall = r_vs_sync[2] && !r_vs_sync[1];

    // Status set sources and W1C masks
    always_comb begin
        w_istat_set               = '0;
        w_istat_set[ISTAT_VBLANK] = w_vsync_fall;
        w_istat_set[ISTAT_UNDER]  = |BUF_UNDER;
        w_istat_set[ISTAT_OVER]   = |r_over_s2;
        w_istat_clr = (w_wr && w_wa == REG_DISPISTAT && BYTEEN[0]) ? WDATA[2:0] : 3'b000;
        w_under_clr = (w_wr && w_wa == REG_DISPFIFO && BYTEEN[0]) ? WDATA[NCH-1:0] : '0;
        w_over_clr  = (w_wr && w_wa == REG_DISPFIFO && BYTEEN[2]) ? WDATA[16 +: NCH] : '0;
    end

    // VSYNC and overflow synchronisers (VSYNC idles high)
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_vs_sync <= 3'b111;
            r_over_s1 <= '0;
            r_over_s2 <= '0;
        end else begin
            r_vs_sync <= {r_vs_sync[1:0], DSP_VSYNC_X};
            r_over_s1 <= BUF_OVER;
            r_over_s2 <= r_over_s1;
        end
    end

    // Global control registers
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_dispon <= 1'b0;
            r_ien    <= 3'b000;
        end else begin
            if (w_wr && w_wa == REG_DISPCTRL && BYTEEN[0]) begin
                r_dispon <= WDATA[0];
            end
            if (w_wr && w_wa == REG_DISPIEN && BYTEEN[0]) begin
                r_ien <= WDATA[2:0];
            end
        end
    end

    // Sticky status flags: a set in the same cycle as a clear wins
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_istat <= 3'b000;
            r_under <= '0;
            r_over  <= '0;
        end else begin
            r_istat <= (r_istat & ~w_istat_clr) | w_istat_set;
            r_under <= (r_under & ~w_under_clr) | BUF_UNDER;
            r_over  <= (r_over & ~w_over_clr) | r_over_s2;
        end
    end

    // Frame counter: any write clears it, otherwise counts displayed frames
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_framecnt <= '0;
        end else if (w_wr && w_wa == REG_FRAMECNT) begin
            r_framecnt <= '0;
        end else if (w_vsync_fall && r_dispon) begin
            r_framecnt <= r_framecnt + FCW'(1);
        end
    end

    // Registered interrupt line
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_istat & r_ien);
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            disp_ch_regs #(
                .AW(AW)
            ) u_ch (
                .i_clk        (ACLK),
                .i_rst_n      (ARST_N),
                .i_shadow_we  (w_wr && w_wa == ch_reg_addr(gi, CH_SHADOW)),
                .i_byteen     (BYTEEN),
                .i_wdata      (WDATA),
                .i_ctrl_we    (w_wr && w_wa == ch_reg_addr(gi, CH_CTRL) && BYTEEN[0]),
                .i_dispon     (r_dispon),
                .i_vsync_fall (w_vsync_fall),
                .o_shadow     (w_shadow[gi]),
                .o_active     (w_active[gi]),
                .o_ch_en      (CH_EN[gi]),
                .o_updreq     (w_updreq[gi])
            );
            assign DISPADDR[gi*AW +: AW] = w_active[gi];
        end
    endgenerate

    // Read mux; anything unmapped (including channels >= NCH) reads 0
    always_comb begin
        RDATA = '0;
        if (RDADDR[15:12] == 4'h0) begin
            case (w_ra)
                REG_DISPCTRL:  RDATA = 32'(r_dispon);
                REG_DISPIEN:   RDATA = 32'(r_ien);
                REG_DISPISTAT: RDATA = 32'(r_istat);
                REG_DISPFIFO: begin
                    RDATA[NCH-1:0]   = r_under;
                    RDATA[16 +: NCH] = r_over;
                end
                REG_FRAMECNT:  RDATA = 32'(r_framecnt);
                default:       RDATA = '0;
            endcase
            for (int c = 0; c < NCH; c++) begin
                if (w_ra == ch_reg_addr(c, CH_SHADOW)) RDATA = 32'(w_shadow[c]);
                if (w_ra == ch_reg_addr(c, CH_CTRL))   RDATA = {30'd0, w_updreq[c], CH_EN[c]};
                if (w_ra == ch_reg_addr(c, CH_ACTIVE)) RDATA = 32'(w_active[c]);
            end
        end
    end

    assign DISPON  = r_dispon;
    assign DSP_IRQ = r_irq;

endmodule

// File: tb/tb_disp_regctrl_mc.sv
// Self-checking bench for disp_regctrl_mc (NCH=2, AW=29, FCW=4).
module tb_disp_regctrl_mc;

    localparam int NCH = 2;
    localparam int AW  = 29;
    localparam int FCW = 4;

    logic              ACLK = 1'b0;
    logic              ARST_N = 1'b0;
    logic              DSP_VSYNC_X = 1'b1;
    logic [15:0]       WRADDR = '0;
    logic [3:0]        BYTEEN = '0;
    logic              WREN = 1'b0;
    logic [31:0]       WDATA = '0;
    logic [15:0]       RDADDR = '0;
    logic              RDEN = 1'b0;
    logic [31:0]       RDATA;
    logic              DISPON;
    logic [NCH-1:0]    CH_EN;
    logic [NCH*AW-1:0] DISPADDR;
    logic              DSP_IRQ;
    logic [NCH-1:0]    BUF_UNDER = '0;
    logic [NCH-1:0]    BUF_OVER = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected read results
    string       q_tag[$];
    logic [31:0] q_exp[$];

    disp_regctrl_mc #(.NCH(NCH), .AW(AW), .FCW(FCW)) dut (
        .ACLK        (ACLK),
        .ARST_N      (ARST_N),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .WRADDR      (WRADDR),
        .BYTEEN      (BYTEEN),
        .WREN        (WREN),
        .WDATA       (WDATA),
        .RDADDR      (RDADDR),
        .RDEN        (RDEN),
        .RDATA       (RDATA),
        .DISPON      (DISPON),
        .CH_EN       (CH_EN),
        .DISPADDR    (DISPADDR),
        .DSP_IRQ     (DSP_IRQ),
        .BUF_UNDER   (BUF_UNDER),
        .BUF_OVER    (BUF_OVER)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Register write; starts at a negedge, ends at the negedge after the sampling edge
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        WRADDR = a;
        WDATA  = d;
        BYTEEN = be;
        WREN   = 1'b1;
        @(negedge ACLK);
        WREN   = 1'b0;
        BYTEEN = 4'h0;
    endtask

    // Register read: expectation queued with the address, compared once RDATA settles
    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
        RDADDR = a;
        RDEN   = 1'b1;
        q_exp.push_back(exp);
        q_tag.push_back(tag);
        #1;
        chk(q_tag.pop_front(), RDATA, q_exp.pop_front());
        RDEN   = 1'b0;
    endtask

    task automatic vs_pulse();
        DSP_VSYNC_X = 1'b0;
        repeat (3) @(negedge ACLK);
        DSP_VSYNC_X = 1'b1;
        repeat (3) @(negedge ACLK);
    endtask

    // Drive VSYNC low and stop in the cycle where the synchronised fall is seen
    task automatic vs_to_fall();
        DSP_VSYNC_X = 1'b0;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic vs_release();
        DSP_VSYNC_X = 1'b1;
        repeat (3) @(negedge ACLK);
    endtask

    function automatic logic [31:0] addr_of(input int c);
        return 32'(DISPADDR[c*AW +: AW]);
    endfunction

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] raddrs [11];
        raddrs = '{16'h000, 16'h004, 16'h008, 16'h00C, 16'h010,
                   16'h100, 16'h104, 16'h108, 16'h110, 16'h114, 16'h118};

        // ---- reset ----
        repeat (3) @(negedge ACLK);
        ARST_N = 1'b1;
        @(negedge ACLK);
        chk("rst_dispon", 32'(DISPON), 32'h0);
        chk("rst_ch_en", 32'(CH_EN), 32'h0);
        chk("rst_addr0", addr_of(0), 32'h0);
        chk("rst_addr1", addr_of(1), 32'h0);
        chk("rst_irq", 32'(DSP_IRQ), 32'h0);
        for (int i = 0; i < 11; i++) rd(raddrs[i], 32'h0, $sformatf("rst_rd_%03h", raddrs[i]));
        @(negedge ACLK);

        // ---- DISPON=0: ACTIVE tracks SHADOW ----
        wr(16'h100, 32'h0123_4560, 4'hF);
        chk("track_not_yet", addr_of(0), 32'h0);
        @(negedge ACLK);
        chk("track_addr0", addr_of(0), 32'h0123_4560);
        wr(16'h100, 32'hFFFF_FFFF, 4'h2);
        rd(16'h100, 32'h0123_FF60, "shadow_byte1");
        wr(16'h100, 32'hFFFF_FFFF, 4'h8);
        rd(16'h100, 32'h1F23_FF60, "shadow_above_aw");
        wr(16'h1000, 32'h1, 4'hF);
        chk("unmapped_wr", 32'(DISPON), 32'h0);
        wr(16'h120, 32'h1234_5678, 4'hF);
        rd(16'h120, 32'h0, "ch2_unmapped");
        @(negedge ACLK);
        rd(16'h108, 32'h1F23_FF60, "active0_track");

        // ---- double buffering ----
        wr(16'h000, 32'h1, 4'h1);
        chk("dispon_on", 32'(DISPON), 32'h1);
        wr(16'h110, 32'h0AAA_0000, 4'hF);
        wr(16'h114, 32'h2, 4'h1);
        rd(16'h114, 32'h2, "updreq_pending");
        rd(16'h118, 32'h0, "active1_held");
        DSP_VSYNC_X = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("vs_2edges", addr_of(1), 32'h0);
        @(negedge ACLK);
        chk("vs_3edges", addr_of(1), 32'h0AAA_0000);
        rd(16'h114, 32'h0, "updreq_cleared");
        rd(16'h010, 32'h1, "framecnt_1");
        rd(16'h008, 32'h1, "istat_vblank");
        chk("active0_kept", addr_of(0), 32'h1F23_FF60);
        vs_release();
        wr(16'h104, 32'h1, 4'h1);
        chk("ch_en0", 32'(CH_EN), 32'h1);
        wr(16'h104, 32'h0, 4'h2);
        chk("ch_en_noben", 32'(CH_EN), 32'h1);

        // ---- interrupt ----
        wr(16'h008, 32'h7, 4'h1);
        rd(16'h008, 32'h0, "istat_w1c");
        wr(16'h004, 32'h1, 4'h1);
        chk("irq_ien_only", 32'(DSP_IRQ), 32'h0);
        DSP_VSYNC_X = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("irq_not_yet", 32'(DSP_IRQ), 32'h0);
        @(negedge ACLK);
        chk("irq_set", 32'(DSP_IRQ), 32'h1);
        vs_release();
        vs_to_fall();
        wr(16'h008, 32'h1, 4'h1);
        rd(16'h008, 32'h1, "istat_set_wins");
        chk("irq_held", 32'(DSP_IRQ), 32'h1);
        vs_release();
        wr(16'h008, 32'h1, 4'h1);
        rd(16'h008, 32'h0, "istat_cleared");
        chk("irq_lag", 32'(DSP_IRQ), 32'h1);
        @(negedge ACLK);
        chk("irq_drop", 32'(DSP_IRQ), 32'h0);

        // ---- SHADOW / UPDREQ writes coinciding with the frame boundary ----
        wr(16'h100, 32'h0000_0100, 4'hF);
        wr(16'h104, 32'h3, 4'h1);
        vs_to_fall();
        wr(16'h100, 32'h0000_0200, 4'hF);
        rd(16'h108, 32'h0000_0100, "shadow_race_old");
        rd(16'h104, 32'h1, "shadow_race_updreq");
        vs_release();
        wr(16'h104, 32'h3, 4'h1);
        vs_to_fall();
        wr(16'h104, 32'h3, 4'h1);
        rd(16'h108, 32'h0000_0200, "updreq_race_xfer");
        rd(16'h104, 32'h3, "updreq_race_kept");
        vs_release();
        rd(16'h010, 32'h5, "framecnt_5");

        // ---- FIFO flags ----
        wr(16'h008, 32'h7, 4'h1);
        BUF_UNDER = 2'b10;
        @(negedge ACLK);
        BUF_UNDER = 2'b00;
        rd(16'h00C, 32'h0000_0002, "under1");
        rd(16'h008, 32'h2, "istat_under");
        chk("irq_masked", 32'(DSP_IRQ), 32'h0);
        BUF_OVER = 2'b01;
        @(negedge ACLK);
        BUF_OVER = 2'b00;
        rd(16'h00C, 32'h0000_0002, "over_1edge");
        @(negedge ACLK);
        rd(16'h00C, 32'h0000_0002, "over_2edges");
        @(negedge ACLK);
        rd(16'h00C, 32'h0001_0002, "over_3edges");
        rd(16'h008, 32'h6, "istat_over");
        wr(16'h004, 32'h6, 4'h1);
        chk("irq_ien_lag", 32'(DSP_IRQ), 32'h0);
        @(negedge ACLK);
        chk("irq_ien6", 32'(DSP_IRQ), 32'h1);
        rd(16'h004, 32'h6, "ien_rd");
        wr(16'h00C, 32'h0001_0000, 4'h1);
        rd(16'h00C, 32'h0001_0002, "over_needs_be2");
        wr(16'h00C, 32'h0001_0002, 4'h5);
        rd(16'h00C, 32'h0, "fifo_w1c");
        BUF_UNDER = 2'b01;
        wr(16'h00C, 32'h0000_0001, 4'h1);
        BUF_UNDER = 2'b00;
        rd(16'h00C, 32'h1, "fifo_set_wins");
        wr(16'h00C, 32'h0000_0001, 4'h1);
        rd(16'h00C, 32'h0, "fifo_clr2");

        // ---- frame counter wrap ----
        wr(16'h010, 32'h0, 4'h0);
        rd(16'h010, 32'h0, "framecnt_clr");
        for (int i = 0; i < 15; i++) vs_pulse();
        rd(16'h010, 32'hF, "framecnt_15");
        vs_pulse();
        rd(16'h010, 32'h0, "framecnt_wrap");

        // ---- display off: no counting, UPDREQ self-clears ----
        wr(16'h000, 32'h0, 4'h1);
        chk("dispon_off", 32'(DISPON), 32'h0);
        @(negedge ACLK);
        rd(16'h104, 32'h1, "updreq_off_clr");
        vs_pulse();
        rd(16'h010, 32'h0, "framecnt_off");

        // ---- asynchronous reset mid-cycle ----
        wr(16'h000, 32'h1, 4'h1);
        #2;
        ARST_N = 1'b0;
        #1;
        chk("arst_dispon", 32'(DISPON), 32'h0);
        chk("arst_ch_en", 32'(CH_EN), 32'h0);
        chk("arst_addr0", addr_of(0), 32'h0);
        chk("arst_addr1", addr_of(1), 32'h0);
        @(negedge ACLK);
        ARST_N = 1'b1;
        @(negedge ACLK);
        rd(16'h100, 32'h0, "arst_shadow0");
        rd(16'h008, 32'h0, "arst_istat");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
